mean_vec_match: RTL

MEAN_VEC_MATCH -- requirements
Module: mean_vec_match

---
 rtl/mean_vec_match_if.sv | 32 +++
 rtl/mean_vec_match.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mean_vec_match_if.sv
// Bundle of sample, template-write and result signals for mean_vec_match.
// master drives samples/template writes, slave is the matcher.
interface mean_vec_match_if #(
  parameter int DATA_WIDTH = 9,
  parameter int IDX_WIDTH  = 2,
  parameter int DIST_WIDTH = 16
);
  logic                         i_valid;
  logic signed [DATA_WIDTH-1:0] i_data;
  logic                         tpl_wr_en;
  logic [IDX_WIDTH+4:0]         tpl_wr_addr;
  logic signed [DATA_WIDTH-1:0] tpl_wr_data;
  logic                         o_valid;
  logic [IDX_WIDTH-1:0]         o_index;
  logic [DIST_WIDTH-1:0]        o_dist;
  logic                         o_busy;
  logic                         o_overrun;

  modport master (
    output i_valid, i_data,
    output tpl_wr_en, tpl_wr_addr, tpl_wr_data,
    input  o_valid, o_index, o_dist,
    input  o_busy, o_overrun
  );

  modport slave (
    input  i_valid, i_data,
    input  tpl_wr_en, tpl_wr_addr, tpl_wr_data,
    output o_valid, o_index, o_dist,
    output o_busy, o_overrun
  );
endinterface

// File: rtl/mean_vec_match.sv
// Collects a mean-sample vector and picks the nearest template by SAD.
// Optional reject threshold: define MEAN_VEC_MATCH_THRESH_EN.
module mean_vec_match #(
  parameter int DATA_WIDTH = 9,
  parameter int VEC_LEN    = 31,
  parameter int TPL_NUM    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DIST_WIDTH = 16,
  parameter logic [DIST_WIDTH-1:0] DIST_THRESH = 16'd2000
) (
  input logic clk,
  input logic rst_n,
  mean_vec_match_if.slave bus
);
  localparam int AW    = IDX_WIDTH + 5;
  localparam int MEM_N = TPL_NUM * VEC_LEN;
  localparam int CW    = $clog2(VEC_LEN);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COLLECT = 4'b0010,
    COMPARE = 4'b0100,
    OUTPUT  = 4'b1000
  } state_t;

  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                elm;
  logic [IDX_WIDTH-1:0]         tpl;
  logic [AW-1:0]                ptr;
  logic [DIST_WIDTH-1:0]        acc;
  logic [DIST_WIDTH-1:0]        best;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic signed [DATA_WIDTH-1:0] vec [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] mem [MEM_N];

  logic signed [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]          mag;
  logic [DIST_WIDTH-1:0]        acc_nx;
  logic                         last_e;
  logic                         last_t;
  logic                         wr_ok;

`ifndef MEAN_VEC_MATCH_THRESH_EN
  logic unused_thr;
  assign unused_thr = ^DIST_THRESH;
`endif

  // Absolute difference of the current element pair and running sum.
  always_comb begin
    diff = {vec[elm][DATA_WIDTH-1], vec[elm]}
         - {mem[ptr][DATA_WIDTH-1], mem[ptr]};
    mag = diff[DATA_WIDTH] ? -diff : diff;
    acc_nx = acc + {{(DIST_WIDTH-DATA_WIDTH-1){1'b0}}, mag};
    last_e = (elm == CW'(VEC_LEN-1));
    last_t = (tpl == IDX_WIDTH'(TPL_NUM-1));
    wr_ok = bus.tpl_wr_en && !bus.o_busy
         && (bus.tpl_wr_addr < AW'(MEM_N));
  end

  // Template memory: writable only while idle/collecting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_N; k++) mem[k] <= '0;
    end else if (wr_ok) begin
      mem[bus.tpl_wr_addr] <= bus.tpl_wr_data;
    end
  end

  // Control FSM: collect vector, scan templates, publish best match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      elm           <= '0;
      tpl           <= '0;
      ptr           <= '0;
      acc           <= '0;
      best          <= '0;
      best_idx      <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_index   <= '0;
      bus.o_dist    <= '0;
      bus.o_busy    <= 1'b0;
      bus.o_overrun <= 1'b0;
      for (int k = 0; k < VEC_LEN; k++) vec[k] <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      if (bus.i_valid && bus.o_busy) bus.o_overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.i_valid) begin
            vec[0] <= bus.i_data;
            cnt    <= CW'(1);
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.i_valid) begin
            vec[cnt] <= bus.i_data;
            if (cnt == CW'(VEC_LEN-1)) begin
              cnt        <= '0;
              elm        <= '0;
              tpl        <= '0;
              ptr        <= '0;
              acc        <= '0;
              bus.o_busy <= 1'b1;
              state      <= COMPARE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMPARE: begin
          ptr <= ptr + 1'b1;
          if (last_e) begin
            elm <= '0;
            acc <= '0;
            tpl <= tpl + 1'b1;
            if (tpl == '0 || acc_nx < best) begin
              best     <= acc_nx;
              best_idx <= tpl;
            end
            if (last_t) state <= OUTPUT;
          end else begin
            elm <= elm + 1'b1;
            acc <= acc_nx;
          end
        end
        OUTPUT: begin
          bus.o_valid <= 1'b1;
          bus.o_dist  <= best;
`ifdef MEAN_VEC_MATCH_THRESH_EN
          bus.o_index <= (best > DIST_THRESH) ? '1 : best_idx;
`else
          bus.o_index <= best_idx;
`endif
          bus.o_busy  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
